cfg_chain_loader: RTL and testbench
===================================

// Module: cfg_chain_loader
// PURPOSE
//   Loads a fabric configuration bitstream into the serial config scan chain.
//   Accepts parallel words from the host-side bitstream source over a valid/ready handshake.
//   Shifts each word out LSB-first, then pulses the chain latch.
//   Holds the user fabric (LUT/FF test designs) in reset until a complete load has succeeded.
// PARAMETERS
//   WORD_WIDTH      8    bits per input word; also bits shifted per word
//   CHAIN_LENGTH    32   config chain length in bits; must be a multiple of WORD_WIDTH
//   TIMEOUT_CYCLES  16   max cycles spent in LOAD without an accepted word before ERROR
// PORTS
//   i_Clock          in   1           single clock; everything is posedge i_Clock
//   i_Reset          in   1           synchronous, active-high reset
//   i_Start          in   1           begin a load; sampled only in IDLE, DONE, ERROR
//   i_Data           in   WORD_WIDTH  bitstream word
//   i_DataValid      in   1           i_Data is valid
//   o_DataReady      out  1           loader accepts i_Data this cycle
//   o_CfgData        out  1           serial config bit
//   o_CfgShiftEnable out  1           chain shifts o_CfgData in this cycle
//   o_CfgLatch       out  1           one-cycle pulse: chain contents to config memory
//   o_FabricReset    out  1           user fabric reset; high unless state == DONE
//   o_Busy           out  1           state is LOAD, SHIFT or LATCH
//   o_Done           out  1           state is DONE
//   o_Error          out  1           state is ERROR
// BEHAVIOUR
//   Reset values
//     - State: IDLE; all counters 0.
//     - Outputs: o_FabricReset=1; all other outputs 0.
//   All outputs are registered or decoded from registered state; no comb path from inputs.
//   Word handshake
//     - A transfer occurs when i_DataValid & o_DataReady.
//     - o_DataReady=1 only in LOAD.
//   State machine
//     - IDLE: i_Start -> LOAD; word/bit counters and timeout cleared.
//     - LOAD: transfer -> capture i_Data into the shift register, reset timeout, go to SHIFT.
//       No transfer -> timeout++; when it reaches TIMEOUT_CYCLES -> ERROR.
//     - SHIFT: WORD_WIDTH cycles. o_CfgShiftEnable=1, o_CfgData=shreg[0], shift right.
//       After the last bit: if words_done == CHAIN_LENGTH/WORD_WIDTH -> LATCH, else -> LOAD.
//     - LATCH: o_CfgLatch=1 for exactly one cycle -> DONE.
//     - DONE: o_FabricReset=0, o_Done=1. i_Start -> LOAD, and o_FabricReset re-asserts
//       in that same next cycle.
//     - ERROR: o_Error=1, o_FabricReset=1. i_Start -> LOAD (fresh load). Otherwise hold.
//   Timing
//     - A word accepted in cycle N drives its bits in cycles N+1..N+WORD_WIDTH.
//     - A word takes WORD_WIDTH+1 cycles; a full load with back-to-back data takes
//       (CHAIN_LENGTH/WORD_WIDTH)*(WORD_WIDTH+1) cycles, then LATCH + 1 cycle to DONE.
//   Boundary rules
//     - i_Start in LOAD/SHIFT/LATCH is ignored.
//     - i_DataValid outside LOAD is ignored; the word is not consumed.
//     - Timeout counter width is clog2(TIMEOUT_CYCLES+1). It counts only in LOAD and
//       clears on each transfer.
//     - i_Reset mid-load returns to IDLE next cycle with no latch pulse; o_CfgShiftEnable=0.
//     - Shift-enable is never high in the same cycle as o_CfgLatch.
// STRUCTURE
//   Shared package cfg_pkg:
//     - state encoding localparams: IDLE, LOAD, SHIFT, LATCH, DONE, ERROR
//     - default CHAIN_LENGTH / WORD_WIDTH for the fabric
//   Sub-module cfg_shift_piso: WORD_WIDTH parallel-load, LSB-first serial-out shift
//   register with load/shift enables.
//   FSM, word/bit counters and timeout live in the top.
// TESTING (WORD_WIDTH=8, CHAIN_LENGTH=32, TIMEOUT_CYCLES=16)
//   1. Start, words 0xA5,0x3C,0xFF,0x01 offered continuously -> o_CfgData sequence
//      10100101 00111100 11111111 10000000, 32 shift-enable cycles, one o_CfgLatch,
//      then o_Done=1 and o_FabricReset=0.
//   2. Start, two words, then i_DataValid=0 -> o_Error=1 after 16 LOAD cycles;
//      no latch; o_FabricReset stays 1.
//   3. i_Start pulsed and i_DataValid held high during SHIFT -> ignored; exactly
//      4 transfers total; o_DataReady never high in SHIFT.
//   4. i_Reset asserted on the 5th shift cycle of word 2 -> IDLE next cycle; all
//      outputs at reset values; a new Start completes a clean load.
//   5. From DONE, i_Start -> o_FabricReset=1 and o_Done=0 next cycle; a full reload of
//      0x00 words gives o_CfgData=0 for all 32 shifts.
//   6. From ERROR, i_Start with 4 valid words -> DONE; o_Error clears on LOAD entry.

Source files
------------

// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared state encoding and fabric defaults for the config chain loader
package cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } cfg_state_t;

  localparam int CFG_WORD_WIDTH     = 8;
  localparam int CFG_CHAIN_LENGTH   = 32;
  localparam int CFG_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/cfg_chain_loader_if.sv
// rtl/cfg_chain_loader_if.sv - bitstream word handshake between host source and loader
interface cfg_chain_loader_if
  import cfg_pkg::*;
#(
  parameter int WORD_WIDTH = CFG_WORD_WIDTH
);

  logic [WORD_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);

endinterface

// File: rtl/cfg_shift_piso.sv
// rtl/cfg_shift_piso.sv - parallel-load, LSB-first serial-out shift register
module cfg_shift_piso
  import cfg_pkg::*;
#(
  parameter int WORD_WIDTH = CFG_WORD_WIDTH
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] data,
  output logic                  serial_out
);

  logic [WORD_WIDTH-1:0] shreg;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= data;
    end else if (shift) begin
      shreg <= {1'b0, shreg[WORD_WIDTH-1:1]};
    end
  end

  assign serial_out = shreg[0];

endmodule

// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - loads bitstream words into the serial config chain and gates fabric reset
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int WORD_WIDTH     = CFG_WORD_WIDTH,
  parameter int CHAIN_LENGTH   = CFG_CHAIN_LENGTH,
  parameter int TIMEOUT_CYCLES = CFG_TIMEOUT_CYCLES
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Start,
  cfg_chain_loader_if.slave  word_if,
  output logic               o_CfgData,
  output logic               o_CfgShiftEnable,
  output logic               o_CfgLatch,
  output logic               o_FabricReset,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Error
);

  localparam int NUM_WORDS = CHAIN_LENGTH / WORD_WIDTH;
  localparam int BIT_W     = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  cfg_state_t        state, state_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [WCNT_W-1:0] words_done, words_n;
  logic [TO_W-1:0]   timeout, timeout_n, timeout_inc;
  logic              piso_load, piso_shift, piso_out, transfer;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      words_done <= '0;
      timeout    <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      words_done <= words_n;
      timeout    <= timeout_n;
    end
  end

  assign transfer    = (state == ST_LOAD) && word_if.data_valid;
  assign timeout_inc = timeout + TO_W'(1);

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    words_n    = words_done;
    timeout_n  = timeout;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_Start) begin
          state_n   = ST_LOAD;
          bit_cnt_n = '0;
          words_n   = '0;
          timeout_n = '0;
        end
      end
      ST_LOAD: begin
        if (transfer) begin
          piso_load = 1'b1;
          timeout_n = '0;
          bit_cnt_n = '0;
          words_n   = words_done + WCNT_W'(1);
          state_n   = ST_SHIFT;
        end else begin
          timeout_n = timeout_inc;
          if (timeout_inc == TO_W'(TIMEOUT_CYCLES)) begin
            state_n = ST_ERROR;
          end
        end
      end
      ST_SHIFT: begin
        piso_shift = 1'b1;
        if (bit_cnt == BIT_W'(WORD_WIDTH - 1)) begin
          bit_cnt_n = '0;
          state_n   = (words_done == WCNT_W'(NUM_WORDS)) ? ST_LATCH : ST_LOAD;
        end else begin
          bit_cnt_n = bit_cnt + BIT_W'(1);
        end
      end
      ST_LATCH: state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
  end

  cfg_shift_piso #(.WORD_WIDTH(WORD_WIDTH)) u_piso (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .load       (piso_load),
    .shift      (piso_shift),
    .data       (word_if.data),
    .serial_out (piso_out)
  );

  // Every output is a decode of registered state so nothing combinational leaks from the inputs.
  assign word_if.data_ready = (state == ST_LOAD);
  assign o_CfgShiftEnable   = (state == ST_SHIFT);
  assign o_CfgData          = (state == ST_SHIFT) && piso_out;
  assign o_CfgLatch         = (state == ST_LATCH);
  assign o_FabricReset      = (state != ST_DONE);
  assign o_Busy             = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_LATCH);
  assign o_Done             = (state == ST_DONE);
  assign o_Error            = (state == ST_ERROR);

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb/tb_cfg_chain_loader.sv - scoreboard bench for cfg_chain_loader
module tb_cfg_chain_loader;
  import cfg_pkg::*;

  logic i_Clock = 1'b0;
  logic i_Reset, i_Start;
  logic o_CfgData, o_CfgShiftEnable, o_CfgLatch, o_FabricReset, o_Busy, o_Done, o_Error;

  cfg_chain_loader_if #(.WORD_WIDTH(8)) word_if ();

  cfg_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(32), .TIMEOUT_CYCLES(16)) dut (
    .i_Clock          (i_Clock),
    .i_Reset          (i_Reset),
    .i_Start          (i_Start),
    .word_if          (word_if),
    .o_CfgData        (o_CfgData),
    .o_CfgShiftEnable (o_CfgShiftEnable),
    .o_CfgLatch       (o_CfgLatch),
    .o_FabricReset    (o_FabricReset),
    .o_Busy           (o_Busy),
    .o_Done           (o_Done),
    .o_Error          (o_Error)
  );

  always #5 i_Clock = ~i_Clock;

  // {ready, shift_en, latch, fabric_reset, busy, done, error, cfg_data}
  localparam logic [7:0] RESET_OUTS = 8'b0001_0000;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer = 0, n_shift = 0, n_latch = 0, n_ones = 0;
  int bad_ready = 0, bad_overlap = 0, bad_extra = 0;
  bit exp_q[$];
  logic [7:0] src_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {word_if.data_ready, o_CfgShiftEnable, o_CfgLatch, o_FabricReset,
            o_Busy, o_Done, o_Error, o_CfgData};
  endfunction

  // Scoreboard: accepted words expand to expected LSB-first bits, consumed on shift cycles.
  always @(negedge i_Clock) begin
    if (word_if.data_valid && word_if.data_ready) begin
      n_xfer++;
      for (int i = 0; i < 8; i++) exp_q.push_back(word_if.data[i]);
    end
    if (o_CfgShiftEnable) begin
      n_shift++;
      if (o_CfgData) n_ones++;
      if (word_if.data_ready) bad_ready++;
      if (o_CfgLatch) bad_overlap++;
      if (exp_q.size() == 0) bad_extra++;
      else check("cfg_bit", {31'd0, o_CfgData}, {31'd0, exp_q.pop_front()});
    end
    if (o_CfgLatch) n_latch++;
  end

  task automatic start_load();
    @(posedge i_Clock); #1;
    i_Start = 1'b1;
    @(posedge i_Clock); #1;
    i_Start = 1'b0;
  endtask

  task automatic drive_words(input int n_words);
    for (int i = 0; i < n_words; i++) begin
      int guard = 0;
      bit got = 1'b0;
      word_if.data       = src_q[i];
      word_if.data_valid = 1'b1;
      while (!got && guard < 200) begin
        @(negedge i_Clock);
        got = word_if.data_ready;
        guard++;
      end
      if (!got) check("xfer_timeout", 0, 1);
      @(posedge i_Clock); #1;
    end
    word_if.data_valid = 1'b0;
  endtask

  task automatic wait_end(output int busy_cycles);
    bit ended = 1'b0;
    busy_cycles = 0;
    for (int g = 0; g < 500 && !ended; g++) begin
      @(negedge i_Clock);
      if (o_Done || o_Error) ended = 1'b1;
      else if (o_Busy) busy_cycles++;
    end
    if (!ended) check("end_timeout", 0, 1);
  endtask

  initial begin
    int bc, x0, s0, l0, o0, rdy;
    bit got_err;
    i_Reset = 1'b1; i_Start = 1'b0;
    word_if.data = '0; word_if.data_valid = 1'b0;
    repeat (3) @(posedge i_Clock); #1;
    check("reset_outs", outs(), RESET_OUTS);
    i_Reset = 1'b0;

    // valid in IDLE must not be consumed
    word_if.data = 8'h77; word_if.data_valid = 1'b1;
    repeat (4) @(posedge i_Clock); #1;
    word_if.data_valid = 1'b0;
    check("idle_outs", outs(), RESET_OUTS);
    check("idle_no_xfer", n_xfer, 0);

    // 1: full load
    src_q = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    x0 = n_xfer; s0 = n_shift; l0 = n_latch;
    start_load();
    fork drive_words(4); wait_end(bc); join
    check("t1_busy_cycles", bc, 37);
    check("t1_shifts", n_shift - s0, 32);
    check("t1_latches", n_latch - l0, 1);
    check("t1_done", {o_Done, o_FabricReset, o_Error}, 3'b100);

    // 5: restart from DONE, all-zero reload
    src_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    s0 = n_shift; o0 = n_ones;
    start_load();
    check("t5_restart", {o_FabricReset, o_Done, o_Busy}, 3'b101);
    fork drive_words(4); wait_end(bc); join
    check("t5_shifts", n_shift - s0, 32);
    check("t5_ones", n_ones - o0, 0);
    check("t5_done", {o_Done, o_FabricReset}, 2'b10);

    // 2: two words then starvation -> timeout
    src_q = '{8'h5A, 8'hC3};
    l0 = n_latch;
    start_load();
    drive_words(2);
    rdy = 0; got_err = 1'b0;
    for (int g = 0; g < 200 && !got_err; g++) begin
      @(negedge i_Clock);
      if (o_Error) got_err = 1'b1;
      else if (word_if.data_ready) rdy++;
    end
    check("t2_error", {31'd0, got_err}, 1);
    check("t2_load_cycles", rdy, 16);
    repeat (3) @(posedge i_Clock); #1;
    check("t2_hold", {o_Error, o_FabricReset, o_Done, o_Busy}, 4'b1100);
    check("t2_no_latch", n_latch - l0, 0);
    exp_q.delete();

    // 6: recover from ERROR
    src_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    l0 = n_latch;
    start_load();
    check("t6_err_clear", {o_Error, o_Busy}, 2'b01);
    fork drive_words(4); wait_end(bc); join
    check("t6_done", {o_Done, o_Error}, 2'b10);
    check("t6_latches", n_latch - l0, 1);

    // 3: start pulses during SHIFT and LATCH are ignored
    src_q = '{8'h81, 8'h7E, 8'h96, 8'h69};
    x0 = n_xfer; s0 = n_shift; l0 = n_latch;
    start_load();
    fork
      drive_words(4);
      wait_end(bc);
      begin
        repeat (3) @(posedge i_Clock); #1; i_Start = 1'b1;
        @(posedge i_Clock); #1; i_Start = 1'b0;
        repeat (10) @(posedge i_Clock); #1; i_Start = 1'b1;
        @(posedge i_Clock); #1; i_Start = 1'b0;
        repeat (21) @(posedge i_Clock); #1; i_Start = 1'b1;
        @(posedge i_Clock); #1; i_Start = 1'b0;
      end
    join
    check("t3_xfers", n_xfer - x0, 4);
    check("t3_busy_cycles", bc, 37);
    check("t3_shifts", n_shift - s0, 32);
    check("t3_latches", n_latch - l0, 1);

    // 4: reset on 5th shift cycle of word 2
    s0 = n_shift; l0 = n_latch;
    word_if.data = 8'h11; word_if.data_valid = 1'b1;
    start_load();
    repeat (14) @(posedge i_Clock); #1;
    check("t4_in_shift", {31'd0, o_CfgShiftEnable}, 1);
    i_Reset = 1'b1;
    @(posedge i_Clock); #1;
    i_Reset = 1'b0; word_if.data_valid = 1'b0;
    exp_q.delete();
    check("t4_reset_outs", outs(), RESET_OUTS);
    check("t4_shifts", n_shift - s0, 13);
    check("t4_no_latch", n_latch - l0, 0);
    src_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    s0 = n_shift;
    start_load();
    fork drive_words(4); wait_end(bc); join
    check("t4_reload_done", {o_Done, o_FabricReset}, 2'b10);
    check("t4_reload_shifts", n_shift - s0, 32);

    check("ready_in_shift", bad_ready, 0);
    check("shift_latch_overlap", bad_overlap, 0);
    check("shift_no_word", bad_extra, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
